// File: rtl/adventure_pkg.sv
// Shared screen geometry, direction codes and FSM state encoding for the room
// collision probe and its helpers.
package adventure_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [7:0] FREE_COLOUR = 8'hFE;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_PROBE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } probe_state_e;

endpackage

// File: rtl/room_collision_probe_if.sv
// Player-request and room-map signals of the collision probe; the slave
// modport is the probe itself, the master modport is the surrounding logic.
interface room_collision_probe_if;

    logic       move_req;
    logic [1:0] dir;
    logic [7:0] wall;
    logic [7:0] mapData;
    logic [9:0] CurrentX;
    logic [8:0] CurrentY;
    logic [9:0] player_x;
    logic [8:0] player_y;
    logic       busy;
    logic       move_ack;
    logic       move_ok;

    modport master (
        output move_req, dir, wall, mapData,
        input  CurrentX, CurrentY, player_x, player_y, busy, move_ack, move_ok
    );

    modport slave (
        input  move_req, dir, wall, mapData,
        output CurrentX, CurrentY, player_x, player_y, busy, move_ack, move_ok
    );

endinterface

// File: rtl/probe_point_gen.sv
// Maps a candidate box origin and probe index to a screen coordinate:
// indices 0..3 are TL/TR/BL/BR corners, 4..7 are top/bottom/left/right midpoints.
module probe_point_gen #(
    parameter int PLAYER_SIZE = 16
) (
    input  logic [9:0] i_cx,
    input  logic [8:0] i_cy,
    input  logic [2:0] i_idx,
    output logic [9:0] o_x,
    output logic [8:0] o_y
);

    localparam logic [9:0] X_FULL = 10'(PLAYER_SIZE - 1);
    localparam logic [9:0] X_HALF = 10'(PLAYER_SIZE / 2);
    localparam logic [8:0] Y_FULL = 9'(PLAYER_SIZE - 1);
    localparam logic [8:0] Y_HALF = 9'(PLAYER_SIZE / 2);

    logic [9:0] w_off_x;
    logic [8:0] w_off_y;

    // Offset of the selected probe point from the box origin
    always_comb begin
        case (i_idx)
            3'd0:    begin w_off_x = 10'd0;  w_off_y = 9'd0;   end
            3'd1:    begin w_off_x = X_FULL; w_off_y = 9'd0;   end
            3'd2:    begin w_off_x = 10'd0;  w_off_y = Y_FULL; end
            3'd3:    begin w_off_x = X_FULL; w_off_y = Y_FULL; end
            3'd4:    begin w_off_x = X_HALF; w_off_y = 9'd0;   end
            3'd5:    begin w_off_x = X_HALF; w_off_y = Y_FULL; end
            3'd6:    begin w_off_x = 10'd0;  w_off_y = Y_HALF; end
            3'd7:    begin w_off_x = X_FULL; w_off_y = Y_HALF; end
            default: begin w_off_x = 10'd0;  w_off_y = 9'd0;   end
        endcase
    end

    assign o_x = i_cx + w_off_x;
    assign o_y = i_cy + w_off_y;

endmodule

// File: rtl/room_collision_probe.sv
// Player position owner: probes the candidate box against the room map and
// commits axis-aligned moves. ROOM_PROBE_MID_EN adds four edge-midpoint probes.
module room_collision_probe
    import adventure_pkg::*;
#(
    parameter int START_X     = 320,
    parameter int START_Y     = 240,
    parameter int PLAYER_SIZE = 16,
    parameter int STEP        = 4
) (
    input  logic                   clk_vga,
    input  logic                   rst,
    room_collision_probe_if.slave  bus
);

`ifdef ROOM_PROBE_MID_EN
    localparam int NUM_PROBES = 8;
`else
    localparam int NUM_PROBES = 4;
`endif
    localparam logic [2:0]        LAST_IDX = 3'(NUM_PROBES - 1);
    localparam logic signed [10:0] L_STEP  = 11'(STEP);
    localparam logic signed [10:0] L_SPAN  = 11'(PLAYER_SIZE - 1);
    localparam logic signed [10:0] L_XMAX  = 11'(H_ACTIVE - 1);
    localparam logic signed [10:0] L_YMAX  = 11'(V_ACTIVE - 1);

    probe_state_e r_state, w_state_nxt;
    dir_e         r_dir, w_dir_nxt;
    logic [2:0]   r_idx, w_idx_nxt;
    logic [9:0]   r_cx, w_cx_nxt, r_cur_x, w_cur_x_nxt, r_px, w_px_nxt;
    logic [8:0]   r_cy, w_cy_nxt, r_cur_y, w_cur_y_nxt, r_py, w_py_nxt;
    logic         r_oob, w_oob_nxt, r_hit, w_hit_nxt;
    logic         r_busy, w_busy_nxt, r_ack, w_ack_nxt, r_ok, w_ok_nxt;

    logic signed [10:0] w_px_s, w_py_s, w_cand_x, w_cand_y;
    logic               w_oob, w_sample;
    logic [9:0]         w_gen_cx, w_gen_x;
    logic [8:0]         w_gen_cy, w_gen_y;
    logic [2:0]         w_gen_idx;

    assign w_px_s   = $signed({1'b0, r_px});
    assign w_py_s   = $signed({2'b00, r_py});
    assign w_sample = (bus.mapData == bus.wall);

    // Candidate origin and off-screen test, signed so moves past 0 go negative
    always_comb begin
        case (r_dir)
            DIR_UP:    begin w_cand_x = w_px_s;          w_cand_y = w_py_s - L_STEP; end
            DIR_DOWN:  begin w_cand_x = w_px_s;          w_cand_y = w_py_s + L_STEP; end
            DIR_LEFT:  begin w_cand_x = w_px_s - L_STEP; w_cand_y = w_py_s;          end
            DIR_RIGHT: begin w_cand_x = w_px_s + L_STEP; w_cand_y = w_py_s;          end
            default:   begin w_cand_x = w_px_s;          w_cand_y = w_py_s;          end
        endcase
        w_oob = (w_cand_x < 11'sd0) || (w_cand_y < 11'sd0) ||
                ((w_cand_x + L_SPAN) > L_XMAX) || ((w_cand_y + L_SPAN) > L_YMAX);
    end

    // CALC feeds the fresh candidate for point 0; PROBE looks one point ahead
    always_comb begin
        if (r_state == ST_CALC) begin
            w_gen_cx  = w_cand_x[9:0];
            w_gen_cy  = w_cand_y[8:0];
            w_gen_idx = 3'd0;
        end else begin
            w_gen_cx  = r_cx;
            w_gen_cy  = r_cy;
            w_gen_idx = r_idx + 3'd1;
        end
    end

    probe_point_gen #(.PLAYER_SIZE(PLAYER_SIZE)) u_point_gen (
        .i_cx  (w_gen_cx),
        .i_cy  (w_gen_cy),
        .i_idx (w_gen_idx),
        .o_x   (w_gen_x),
        .o_y   (w_gen_y)
    );

    // FSM state register
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; requests outside IDLE are dropped
    always_comb begin
        case (r_state)
            ST_IDLE:  w_state_nxt = bus.move_req ? ST_CALC : ST_IDLE;
            ST_CALC:  w_state_nxt = ST_PROBE;
            ST_PROBE: w_state_nxt = (r_idx == LAST_IDX) ? ST_DRAIN : ST_PROBE;
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of every datapath and output register
    always_comb begin
        w_dir_nxt   = r_dir;
        w_idx_nxt   = r_idx;
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_oob_nxt   = r_oob;
        w_hit_nxt   = r_hit;
        w_cur_x_nxt = r_cur_x;
        w_cur_y_nxt = r_cur_y;
        w_px_nxt    = r_px;
        w_py_nxt    = r_py;
        w_busy_nxt  = 1'b0;
        w_ack_nxt   = 1'b0;
        w_ok_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.move_req) begin
                    w_dir_nxt  = dir_e'(bus.dir);
                    w_busy_nxt = 1'b1;
                end else begin
                    w_busy_nxt = 1'b0;
                end
            end
            ST_CALC: begin
                w_busy_nxt  = 1'b1;
                w_idx_nxt   = 3'd0;
                w_cx_nxt    = w_cand_x[9:0];
                w_cy_nxt    = w_cand_y[8:0];
                w_oob_nxt   = w_oob;
                w_hit_nxt   = 1'b0;
                w_cur_x_nxt = w_gen_x;
                w_cur_y_nxt = w_gen_y;
            end
            ST_PROBE: begin
                w_busy_nxt = 1'b1;
                w_idx_nxt  = r_idx + 3'd1;
                // mapData lags the address by a cycle, so the first probe cycle has nothing to sample
                if (r_idx != 3'd0) begin
                    w_hit_nxt = r_hit | w_sample;
                end else begin
                    w_hit_nxt = r_hit;
                end
                if (r_idx != LAST_IDX) begin
                    w_cur_x_nxt = w_gen_x;
                    w_cur_y_nxt = w_gen_y;
                end else begin
                    w_cur_x_nxt = r_cur_x;
                    w_cur_y_nxt = r_cur_y;
                end
            end
            ST_DRAIN: begin
                w_hit_nxt = r_hit | w_sample;
                w_ack_nxt = 1'b1;
                w_ok_nxt  = ~(r_hit | w_sample) & ~r_oob;
                if (w_ok_nxt) begin
                    w_px_nxt = r_cx;
                    w_py_nxt = r_cy;
                end else begin
                    w_px_nxt = r_px;
                    w_py_nxt = r_py;
                end
            end
            ST_DONE: begin
                w_busy_nxt = 1'b0;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_dir   <= DIR_UP;
            r_idx   <= 3'd0;
            r_cx    <= 10'd0;
            r_cy    <= 9'd0;
            r_oob   <= 1'b0;
            r_hit   <= 1'b0;
            r_cur_x <= 10'd0;
            r_cur_y <= 9'd0;
            r_px    <= 10'(START_X);
            r_py    <= 9'(START_Y);
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_ok    <= 1'b0;
        end else begin
            r_dir   <= w_dir_nxt;
            r_idx   <= w_idx_nxt;
            r_cx    <= w_cx_nxt;
            r_cy    <= w_cy_nxt;
            r_oob   <= w_oob_nxt;
            r_hit   <= w_hit_nxt;
            r_cur_x <= w_cur_x_nxt;
            r_cur_y <= w_cur_y_nxt;
            r_px    <= w_px_nxt;
            r_py    <= w_py_nxt;
            r_busy  <= w_busy_nxt;
            r_ack   <= w_ack_nxt;
            r_ok    <= w_ok_nxt;
        end
    end

    assign bus.CurrentX = r_cur_x;
    assign bus.CurrentY = r_cur_y;
    assign bus.player_x = r_px;
    assign bus.player_y = r_py;
    assign bus.busy     = r_busy;
    assign bus.move_ack = r_ack;
    assign bus.move_ok  = r_ok;

endmodule

// File: tb/tb_room_collision_probe.sv
// Directed bench for room_collision_probe against a registered room map model
// (wall 8'h1C); honours ROOM_PROBE_MID_EN for probe count and latency.
module tb_room_collision_probe;
    import adventure_pkg::*;

`ifdef ROOM_PROBE_MID_EN
    localparam int LAT    = 11;
    localparam int NPROBE = 8;
`else
    localparam int LAT    = 7;
    localparam int NPROBE = 4;
`endif
    localparam logic [7:0] WALL = 8'h1C;

    typedef struct {
        int         setup;   // 0 none, 1..3 reset and walk to a start position
        logic [1:0] d;
        int         ok;
        int         x;
        int         y;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    int exp_x [8] = '{324, 339, 324, 339, 332, 332, 324, 339};
    int exp_y [8] = '{240, 240, 255, 255, 240, 255, 248, 248};
    vec_t vecs [7];

    room_collision_probe_if bus ();

    room_collision_probe #(
        .START_X(320), .START_Y(240), .PLAYER_SIZE(16), .STEP(4)
    ) dut (
        .clk_vga (clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] room_colour(input logic [9:0] x, input logic [8:0] y);
        if (x < 10'd40 || y >= 9'd440 || (y < 9'd40 && !(x >= 10'd260 && x < 10'd380)))
            return WALL;
        else
            return FREE_COLOUR;
    endfunction

    always_ff @(posedge clk) bus.mapData <= room_colour(bus.CurrentX, bus.CurrentY);

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Issues one request just after an edge; returns result at ack and leaves FSM idle
    task automatic do_move(input logic [1:0] d, output int ok, output int x,
                           output int y, output int lat, output int busy_at_ack);
        bus.move_req = 1'b1;
        bus.dir      = d;
        @(posedge clk); #1;
        bus.move_req = 1'b0;
        lat = 1;
        while (!bus.move_ack && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        ok          = int'(bus.move_ack & bus.move_ok);
        x           = int'(bus.player_x);
        y           = int'(bus.player_y);
        busy_at_ack = int'(bus.busy);
        @(posedge clk); #1;
    endtask

    task automatic walk(input logic [1:0] d, input int n);
        int ok, x, y, lat, b;
        for (int i = 0; i < n; i++) begin
            do_move(d, ok, x, y, lat, b);
            check("walk_ok", ok, 1);
        end
    endtask

    initial begin
        int ok, x, y, lat, b, acks;

        bus.move_req = 1'b0;
        bus.dir      = 2'd0;
        bus.wall     = WALL;

        vecs[0] = '{1, DIR_LEFT,  1,  40, 100};
        vecs[1] = '{0, DIR_LEFT,  0,  40, 100};
        vecs[2] = '{0, DIR_RIGHT, 1,  44, 100};
        vecs[3] = '{2, DIR_UP,    1, 300,   0};
        vecs[4] = '{0, DIR_UP,    0, 300,   0};
        vecs[5] = '{3, DIR_DOWN,  1, 100, 424};
        vecs[6] = '{0, DIR_DOWN,  0, 100, 424};

        do_reset();
        check("rst_px",   int'(bus.player_x), 320);
        check("rst_py",   int'(bus.player_y), 240);
        check("rst_curx", int'(bus.CurrentX), 0);
        check("rst_cury", int'(bus.CurrentY), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ack",  int'(bus.move_ack), 0);
        check("rst_ok",   int'(bus.move_ok), 0);

        // Right from reset: probe address sequence and ack timing
        bus.move_req = 1'b1;
        bus.dir      = DIR_RIGHT;
        for (int c = 1; c <= LAT; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                bus.move_req = 1'b0;
                check("busy_c1", int'(bus.busy), 1);
            end
            if (c >= 2 && c < 2 + NPROBE) begin
                check("probe_x", int'(bus.CurrentX), exp_x[c-2]);
                check("probe_y", int'(bus.CurrentY), exp_y[c-2]);
            end
            if (c == LAT - 1) check("ack_early", int'(bus.move_ack), 0);
        end
        check("seq_ack",  int'(bus.move_ack), 1);
        check("seq_ok",   int'(bus.move_ok), 1);
        check("seq_px",   int'(bus.player_x), 324);
        check("seq_py",   int'(bus.player_y), 240);
        check("seq_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        check("ack_pulse", int'(bus.move_ack), 0);

        // Second request mid-operation is dropped; dir change has no effect
        acks = 0;
        bus.move_req = 1'b1;
        bus.dir      = DIR_RIGHT;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.move_req = 1'b0;
            if (c == 3) begin bus.move_req = 1'b1; bus.dir = DIR_UP; end
            if (c == 4) bus.move_req = 1'b0;
            if (bus.move_ack) acks++;
        end
        check("dbl_acks", acks, 1);
        check("dbl_px", int'(bus.player_x), 328);
        check("dbl_py", int'(bus.player_y), 240);

        // Reset in cycle 4 aborts the move with no ack
        acks = 0;
        bus.move_req = 1'b1;
        bus.dir      = DIR_RIGHT;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (c == 1) bus.move_req = 1'b0;
            if (c == 4) rst = 1'b1;
            if (c == 5) rst = 1'b0;
            if (bus.move_ack) acks++;
        end
        check("abort_acks", acks, 0);
        check("abort_px",   int'(bus.player_x), 320);
        check("abort_py",   int'(bus.player_y), 240);
        check("abort_busy", int'(bus.busy), 0);

        for (int i = 0; i < 7; i++) begin
            case (vecs[i].setup)
                1: begin do_reset(); walk(DIR_UP, 35); walk(DIR_LEFT, 69); end
                2: begin do_reset(); walk(DIR_LEFT, 5); walk(DIR_UP, 59); end
                3: begin do_reset(); walk(DIR_LEFT, 55); walk(DIR_DOWN, 45); end
                default: ;
            endcase
            do_move(vecs[i].d, ok, x, y, lat, b);
            check($sformatf("vec%0d_ok", i),   ok,  vecs[i].ok);
            check($sformatf("vec%0d_x", i),    x,   vecs[i].x);
            check($sformatf("vec%0d_y", i),    y,   vecs[i].y);
            check($sformatf("vec%0d_lat", i),  lat, LAT);
            check($sformatf("vec%0d_busy", i), b,   0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
